// File: rtl/datapath_pkg.sv
// Shared types for the micro-op datapath: op codes and sequencer states.
package datapath_pkg;

  typedef enum logic [1:0] {
    OP_LDI  = 2'b00,
    OP_ADDI = 2'b01,
    OP_ADD  = 2'b10,
    OP_MOV  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_T0   = 2'b01,
    S_T1   = 2'b10,
    S_T2   = 2'b11
  } state_t;

endpackage

// File: rtl/dp_regfile.sv
// General register file: one synchronous write port, three combinational
// read ports (operand A, operand B, debug). Indices >= NUM_REGS write
// nothing and read as zero.
module dp_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              we,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  a_sel,
  output logic [DATA_W-1:0] a_data,
  input  logic [SEL_W-1:0]  b_sel,
  output logic [DATA_W-1:0] b_data,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [DATA_W-1:0] d_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  function automatic logic [DATA_W-1:0] rd(input logic [SEL_W-1:0] s);
    rd = (int'(s) < NUM_REGS) ? regs[s] : '0;
  endfunction

  // Register array update: clear wins, otherwise write the selected entry.
  always_ff @(posedge clock) begin
    if (clear) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (we && int'(wr_sel) == i) regs[i] <= wr_data;
    end
  end

  assign a_data = rd(a_sel);
  assign b_data = rd(b_sel);
  assign d_data = rd(d_sel);

endmodule

// File: rtl/microop_datapath.sv
// Bus datapath with built-in T0/T1/T2 micro-sequencer: one register-transfer
// op per accepted start. Optional carry/zero flags under DATAPATH_FLAGS_EN.
module microop_datapath
  import datapath_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [SEL_W-1:0]  src,
  input  logic [SEL_W-1:0]  dst,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data
`ifdef DATAPATH_FLAGS_EN
  ,
  output logic              carry,
  output logic              zero
`endif
);

  state_t            state, state_n;
  op_t               op_q;
  logic [SEL_W-1:0]  src_q, dst_q;
  logic [DATA_W-1:0] imm_q, y_q, z_q, z_next;
  logic [DATA_W-1:0] rf_a, rf_b, opa, opb;
  logic              done_q;
  logic              accept;

  assign accept = (state == S_IDLE) && start;
  assign busy   = (state != S_IDLE);
  assign done   = done_q;

  dp_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_rf (
    .clock  (clock),
    .clear  (clear),
    .we     (state == S_T2),
    .wr_sel (dst_q),
    .wr_data(z_q),
    .a_sel  (src_q),
    .a_data (rf_a),
    .b_sel  (dst_q),
    .b_data (rf_b),
    .d_sel  (rd_sel),
    .d_data (rd_data)
  );

  // Operand select from the latched op.
  always_comb begin
    opa = (op_q == OP_LDI) ? '0 : rf_a;
    opb = '0;
    case (op_q)
      OP_LDI, OP_ADDI: opb = imm_q;
      OP_ADD:          opb = rf_b;
      default:         opb = '0;
    endcase
  end

`ifdef DATAPATH_FLAGS_EN
  logic carry_n;
  assign {carry_n, z_next} = {1'b0, y_q} + {1'b0, opb};
`else
  assign z_next = y_q + opb;
`endif

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state: fixed three-step walk, start only honoured in IDLE.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_T0;
      S_T0:    state_n = S_T1;
      S_T1:    state_n = S_T2;
      default: state_n = S_IDLE;
    endcase
  end

  // Op field latch, Y/Z result latches and the done pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      op_q   <= OP_LDI;
      src_q  <= '0;
      dst_q  <= '0;
      imm_q  <= '0;
      y_q    <= '0;
      z_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_T2);
      if (accept) begin
        op_q  <= op_t'(op);
        src_q <= src;
        dst_q <= dst;
        imm_q <= imm;
      end
      if (state == S_T0) y_q <= opa;
      if (state == S_T1) z_q <= z_next;
    end
  end

`ifdef DATAPATH_FLAGS_EN
  // Flags: carry from the T1 add, zero from Z at the write step; held otherwise.
  always_ff @(posedge clock) begin
    if (clear) begin
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      if (state == S_T1) carry <= carry_n;
      if (state == S_T2) zero  <= (z_q == '0);
    end
  end
`endif

endmodule

// File: tb/tb_microop_datapath.sv
// Scoreboard bench for microop_datapath (DATA_W=8, NUM_REGS=4). Stimulus
// pushes the expected register file / flags / done cycle per op; the monitor
// pops and compares whenever done is seen.
module tb_microop_datapath;

  localparam int DATA_W = 8;
  localparam int NUM_REGS = 4;
  localparam int SEL_W = 2;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        op = '0;
  logic [SEL_W-1:0]  src = '0, dst = '0, rd_sel;
  logic [DATA_W-1:0] imm = '0, rd_data;
  logic              busy, done;
  logic              carry, zero;

  microop_datapath #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clock  (clock),
    .clear  (clear),
    .start  (start),
    .op     (op),
    .src    (src),
    .dst    (dst),
    .imm    (imm),
    .busy   (busy),
    .done   (done),
    .rd_sel (rd_sel),
    .rd_data(rd_data)
`ifdef DATAPATH_FLAGS_EN
    ,
    .carry  (carry),
    .zero   (zero)
`endif
  );

`ifndef DATAPATH_FLAGS_EN
  assign carry = 1'b0;
  assign zero  = 1'b0;
`endif

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int                    cyc;
    logic [3:0][7:0]       regs;
    logic                  c;
    logic                  z;
  } exp_t;

  exp_t            q[$];
  logic [3:0][7:0] shadow = '0;
  int              total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one op; after the accept edge scramble the inputs (they must be
  // ignored) and push the expected result. Returns in the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [1:0] s, input logic [1:0] d,
                        input logic [7:0] i, input logic [7:0] res,
                        input logic c, input logic z, input logic hold, output int acc);
    op = o; src = s; dst = d; imm = i; start = 1'b1;
    @(posedge clock); #1;
    acc = cyc;
    start = hold;
    op = ~o; src = ~s; dst = ~d; imm = ~i;
    shadow[d] = res;
    q.push_back('{acc + 3, shadow, c, z});
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Monitor: reset state, then per-done scoreboard check.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    rd_sel = '0;
    @(negedge clock);
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_sel = SEL_W'(i); #1;
      chk($sformatf("reset_r%0d", i), rd_data, 0);
    end
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    forever begin
      @(negedge clock);
      if (done) begin
        chk("busy_len", run, 3);
        chk("busy_at_done", busy, 0);
        if (q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          for (int i = 0; i < NUM_REGS; i++) begin
            rd_sel = SEL_W'(i); #1;
            chk($sformatf("r%0d", i), rd_data, e.regs[i]);
          end
`ifdef DATAPATH_FLAGS_EN
          chk("carry", carry, e.c);
          chk("zero", zero, e.z);
`endif
        end
        run = 0;
      end else if (busy) begin
        run++;
      end else begin
        run = 0;
      end
    end
  end

  // Directed stimulus.
  initial begin
    int acc, acc2;
    repeat (3) @(posedge clock);
    #1 clear = 1'b0;

    // LDI R0,#05 ; ADDI R1=R0+#05
    run_op(2'b00, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, acc);
    run_op(2'b01, 2'd0, 2'd1, 8'h05, 8'h0A, 1'b0, 1'b0, 1'b0, acc);
    // LDI R2,#FF ; ADDI R3=R2+#02 (carry) ; MOV R0=R3
    run_op(2'b00, 2'd0, 2'd2, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, acc);
    run_op(2'b01, 2'd2, 2'd3, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0, acc);
    run_op(2'b11, 2'd3, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, acc);
    // ADD dst=R1 src=R1 doubles R1
    run_op(2'b10, 2'd1, 2'd1, 8'h00, 8'h14, 1'b0, 1'b0, 1'b0, acc);

    // LDI R3,#77 with start re-pulsed in T0 and T1 using other ops
    op = 2'b00; src = 2'd0; dst = 2'd3; imm = 8'h77; start = 1'b1;
    @(posedge clock); #1;
    acc = cyc;
    shadow[3] = 8'h77;
    q.push_back('{acc + 3, shadow, 1'b0, 1'b0});
    op = 2'b01; src = 2'd1; dst = 2'd3; imm = 8'h10;         // T0
    @(posedge clock); #1;
    op = 2'b10; src = 2'd2; dst = 2'd0; imm = 8'h55;         // T1
    @(posedge clock); #1;
    start = 1'b0;                                            // T2
    @(posedge clock); #1;                                    // done cycle

    // LDI R2,#33 aborted by clear in T1
    op = 2'b00; src = 2'd0; dst = 2'd2; imm = 8'h33; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;                                    // T1
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    shadow = '0;
    repeat (4) @(posedge clock);
    #1;

    // Next op after abort runs normally
    run_op(2'b00, 2'd0, 2'd1, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, acc);

    // start held high: LDI R0,#FF then ADDI R0=R0+#01 at a 4-cycle period
    run_op(2'b00, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, acc);
    run_op(2'b01, 2'd0, 2'd0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, acc2);
    chk("b2b_period", acc2 - acc, 4);

    // drain the scoreboard, bounded
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clock);
    chk("drain", q.size(), 0);
    repeat (5) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
